signed_divider_seq: RTL and testbench

//  Iterative signed fixed-point divider: dout = (din << FRAC) / W, in the same Q1.14 two's-complement

---
 rtl/signed_divider_seq_pkg.sv | 25 ++
 rtl/signed_divider_seq_div_step.sv | 23 ++
 rtl/signed_divider_seq.sv | 124 ++++++++++++
 tb/tb_signed_divider_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/signed_divider_seq_pkg.sv
// Shared Q1.14 fixed-point constants, divider state encoding and the sign helper
// used by the sequential signed divider.
package signed_divider_seq_pkg;

   localparam int WIDTH = 16;
   localparam int FRAC  = 14;
   localparam int QW    = WIDTH + FRAC;
   localparam int CW    = $clog2(QW);

   localparam logic [WIDTH-1:0] QMAX = 16'h7FFF;
   localparam logic [WIDTH-1:0] QMIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN,
      DONE
   } state_t;

   // Two's-complement negate when do_neg is set; -QMIN wraps to 2^(WIDTH-1) as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic do_neg);
      return do_neg ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/signed_divider_seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the
// divisor when it fits and report the resulting quotient bit.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      shifted  = {rem, next_bit};
      diff     = shifted[WIDTH:0] - {1'b0, divisor};
      q_bit    = (shifted >= {2'b00, divisor});
      rem_next = q_bit ? diff : shifted[WIDTH:0];
   end

endmodule

// File: rtl/signed_divider_seq.sv
// Iterative signed Q1.14 divider, dout = (din << FRAC) / W, one quotient bit per
// clock on magnitudes, truncated toward zero and saturated to the Q1.14 range.
module signed_divider_seq
   import signed_divider_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] W,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             ovf,
   output logic             dz
);

   state_t           state, state_nxt;
   logic [QW-1:0]    dividend;
   logic [QW-1:0]    quot;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] divisor;
   logic [CW-1:0]    cnt;
   logic             neg;
   logic             q_bit;
   logic             accept;
   logic [WIDTH-1:0] result;
   logic             result_ovf;

   assign accept = in_valid && (state == IDLE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .next_bit (dividend[QW-1]),
      .divisor  (divisor),
      .rem_next (rem_nxt),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (W == '0) ? FIN : CALC;
         CALC: if (cnt == '0) state_nxt = FIN;
         FIN:  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Sign and saturation: a negative quotient may reach 2^(WIDTH-1) exactly, a positive one may not.
   always_comb begin
      result     = '0;
      result_ovf = 1'b0;
      if (dz) begin
         if (dividend != '0) result = neg ? QMIN : QMAX;
      end else if (!neg) begin
         if (quot > {{(QW-WIDTH){1'b0}}, QMAX}) begin
            result     = QMAX;
            result_ovf = 1'b1;
         end else begin
            result = quot[WIDTH-1:0];
         end
      end else begin
         if (quot > {{(QW-WIDTH){1'b0}}, QMIN}) begin
            result     = QMIN;
            result_ovf = 1'b1;
         end else begin
            result = cond_negate(quot[WIDTH-1:0], 1'b1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dividend <= '0;
         quot     <= '0;
         rem      <= '0;
         divisor  <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         dout     <= '0;
         ovf      <= 1'b0;
         dz       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               neg      <= din[WIDTH-1] ^ W[WIDTH-1];
               dividend <= {cond_negate(din, din[WIDTH-1]), {FRAC{1'b0}}};
               divisor  <= cond_negate(W, W[WIDTH-1]);
               rem      <= '0;
               quot     <= '0;
               cnt      <= CW'(QW - 1);
               ovf      <= 1'b0;
               dz       <= (W == '0);
            end
            CALC: begin
               dividend <= {dividend[QW-2:0], 1'b0};
               rem      <= rem_nxt;
               quot     <= {quot[QW-2:0], q_bit};
               cnt      <= cnt - 1'b1;
            end
            FIN: begin
               dout <= result;
               ovf  <= result_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Directed and model-checked bench for signed_divider_seq: latency, rounding,
// saturation, divide-by-zero, backpressure and mid-operation reset.
module tb_signed_divider_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] din;
   logic [15:0] W;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout;
   logic        ovf;
   logic        dz;

   int checkCount = 0;
   int passCount  = 0;

   signed_divider_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .W         (W),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .ovf       (ovf),
      .dz        (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
   endtask

   // Independent reference: integer divide truncates toward zero, then saturate.
   function automatic void refDiv(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic o, output logic z);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      o = 1'b0;
      z = 1'b0;
      q = 16'h0000;
      if (sb == 0) begin
         z = 1'b1;
         if (sa > 0) q = 16'h7FFF;
         else if (sa < 0) q = 16'h8000;
      end else begin
         r = (sa * 16384) / sb;
         if (r > 32767) begin
            q = 16'h7FFF;
            o = 1'b1;
         end else if (r < -32768) begin
            q = 16'h8000;
            o = 1'b1;
         end else begin
            q = r[15:0];
         end
      end
   endfunction

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
      din      = a;
      W        = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic waitOutValid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expDout, input logic expOvf, input logic expDz,
                        input int holdCycles);
      int lat;
      applyStimulus(a, b);
      waitOutValid(lat);
      checkOutput({tag, " latency"}, 32'(lat), (b == 16'h0) ? 32'd1 : 32'd31);
      checkOutput({tag, " dout"}, 32'(dout), 32'(expDout));
      checkOutput({tag, " ovf"}, 32'(ovf), 32'(expOvf));
      checkOutput({tag, " dz"}, 32'(dz), 32'(expDz));
      repeat (holdCycles) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb, rq;
      logic        ro, rz;
      int          lat;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      W         = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset dout", 32'(dout), 32'd0);
      checkOutput("reset ovf", 32'(ovf), 32'd0);
      checkOutput("reset dz", 32'(dz), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed vectors");
      runOp("0.25/0.75",   16'h1000, 16'h3000, 16'h1555, 1'b0, 1'b0, 0);
      runOp("-0.25/0.75",  16'hF000, 16'h3000, 16'hEAAB, 1'b0, 1'b0, 0);
      runOp("0.5/-1",      16'h2000, 16'hC000, 16'hE000, 1'b0, 1'b0, 0);
      runOp("-1/-1",       16'hC000, 16'hC000, 16'h4000, 1'b0, 1'b0, 0);
      runOp("1/0.5 sat",   16'h4000, 16'h2000, 16'h7FFF, 1'b1, 1'b0, 0);
      runOp("-1/0.5 min",  16'hC000, 16'h2000, 16'h8000, 1'b0, 1'b0, 0);
      runOp("-2/0.25 sat", 16'h8000, 16'h1000, 16'h8000, 1'b1, 1'b0, 0);
      runOp("max/max",     16'h7FFF, 16'h7FFF, 16'h4000, 1'b0, 1'b0, 0);
      runOp("-lsb/1",      16'hFFFF, 16'h4000, 16'hFFFF, 1'b0, 1'b0, 0);
      runOp("neg zero",    16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 0);
      runOp("zero/-1",     16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b0, 0);
      runOp("dz pos",      16'h0123, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 0);
      runOp("dz neg",      16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1, 0);
      runOp("dz zero",     16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0);

      $display("[TB] backpressure");
      applyStimulus(16'h1000, 16'h3000);
      waitOutValid(lat);
      checkOutput("bp latency", 32'(lat), 32'd31);
      din      = 16'h2000;
      W        = 16'hC000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("bp out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp dout", 32'(dout), 32'h1555);
         checkOutput("bp flags", 32'({ovf, dz}), 32'd0);
         checkOutput("bp in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
      checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp second taken", 32'(in_ready), 32'd0);
      waitOutValid(lat);
      checkOutput("bp second latency", 32'(lat), 32'd31);
      checkOutput("bp second dout", 32'(dout), 32'hE000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      $display("[TB] reset during CALC");
      applyStimulus(16'hF000, 16'h3000);
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
      checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset dout", 32'(dout), 32'd0);
      checkOutput("midreset flags", 32'({ovf, dz}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      runOp("after reset", 16'h1000, 16'h3000, 16'h1555, 1'b0, 1'b0, 0);

      $display("[TB] model-checked operands");
      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
         if ($urandom_range(0, 3) == 0) rb = {2'b00, rb[13:0]} | 16'h0001;
         refDiv(ra, rb, rq, ro, rz);
         runOp("random", ra, rb, rq, ro, rz, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
